// File: rtl/pid_scheduler.sv
// pid_scheduler: round-robin issue of per-channel samples to a shared PID
// filter with a per-channel read-after-write lockout.
//
// Ports:
//   clk_in        - sole clock, rising edge
//   rst_in        - asynchronous active-high reset
//   src_dv_in     - per-channel one-cycle sample strobe
//   src_data_in   - per-channel signed samples, channel i at [i*W_DIN +: W_DIN]
//   chan_en_in    - per-channel enable
//   dv_out        - registered issue strobe to the PID filter
//   chan_out      - registered issued channel index (holds when idle)
//   data_out      - registered issued sample (holds when idle)
//   ovf_out       - one-cycle pulse when a pending sample is overwritten
//   drop_cnt_out  - per-channel 16-bit saturating overwrite counters
//
// Optional feature: define PID_SCHED_DROP_CNT_EN to build the drop
// counters; without it drop_cnt_out is tied to zero.

module pid_scheduler #(
    parameter int N_CHAN  = 8,
    parameter int W_CHAN  = 5,
    parameter int W_DIN   = 18,
    parameter int LOCKOUT = 6
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [N_CHAN-1:0]       src_dv_in,
    input  logic [N_CHAN*W_DIN-1:0] src_data_in,
    input  logic [N_CHAN-1:0]       chan_en_in,
    output logic                    dv_out,
    output logic [W_CHAN-1:0]       chan_out,
    output logic [W_DIN-1:0]        data_out,
    output logic [N_CHAN-1:0]       ovf_out,
    output logic [N_CHAN*16-1:0]    drop_cnt_out
);

    localparam int W_LK = (LOCKOUT > 1) ? $clog2(LOCKOUT + 1) : 1;
    localparam logic [W_LK-1:0]   LK_LOAD = W_LK'(LOCKOUT);
    localparam logic [W_CHAN-1:0] RR_RST  = W_CHAN'(N_CHAN - 1);

    // Per-channel state
    logic [W_DIN-1:0]  samp_q [N_CHAN];
    logic [W_DIN-1:0]  samp_d [N_CHAN];
    logic [W_LK-1:0]   lock_q [N_CHAN];
    logic [W_LK-1:0]   lock_d [N_CHAN];
    logic [N_CHAN-1:0] pend_q;
    logic [N_CHAN-1:0] pend_d;
    logic [N_CHAN-1:0] ovf_q;
    logic [N_CHAN-1:0] ovf_d;

    // Arbiter state
    logic [W_CHAN-1:0] rr_q;
    logic [W_CHAN-1:0] rr_d;

    // Output registers
    logic              dv_q;
    logic              dv_d;
    logic [W_CHAN-1:0] chan_q;
    logic [W_CHAN-1:0] chan_d;
    logic [W_DIN-1:0]  data_q;
    logic [W_DIN-1:0]  data_d;

    // Arbitration signals
    logic [N_CHAN-1:0] elig;
    logic [N_CHAN-1:0] gnt_oh;
    logic              gnt_vld;
    logic [W_CHAN-1:0] gnt_idx;
    logic              lo_vld;
    logic [W_CHAN-1:0] lo_idx;
    logic              hi_vld;
    logic [W_CHAN-1:0] hi_idx;

    // Eligibility
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            elig[i] = pend_q[i] && chan_en_in[i] && (lock_q[i] == '0);
        end
    end

    // Round-robin pick: the lowest eligible index above the last grant
    // wins; if none lies above it, wrap to the lowest eligible overall.
    always_comb begin
        lo_vld = 1'b0;
        lo_idx = '0;
        hi_vld = 1'b0;
        hi_idx = '0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_vld = 1'b1;
                lo_idx = W_CHAN'(i);
            end
            if (elig[i] && (i > int'(rr_q))) begin
                hi_vld = 1'b1;
                hi_idx = W_CHAN'(i);
            end
        end
        gnt_vld = lo_vld;
        gnt_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            gnt_oh[i] = gnt_vld && (gnt_idx == W_CHAN'(i));
        end
    end

    // Per-channel next state
    always_comb begin
        pend_d = pend_q;
        ovf_d  = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            samp_d[i] = samp_q[i];

            // Lockout runs down regardless of enable, strobes or pending.
            if (gnt_oh[i]) begin
                lock_d[i] = LK_LOAD;
            end else if (lock_q[i] != '0) begin
                lock_d[i] = lock_q[i] - W_LK'(1);
            end else begin
                lock_d[i] = '0;
            end

            if (!chan_en_in[i]) begin
                // Disabled: drop any held sample silently, ignore strobes.
                pend_d[i] = 1'b0;
            end else begin
                if (gnt_oh[i]) begin
                    pend_d[i] = 1'b0;
                end
                if (src_dv_in[i]) begin
                    // A strobe on the granted channel refills it behind the
                    // issue; only an ungranted pending sample is lost.
                    samp_d[i] = src_data_in[i*W_DIN +: W_DIN];
                    pend_d[i] = 1'b1;
                    ovf_d[i]  = pend_q[i] && !gnt_oh[i];
                end
            end
        end
    end

    // Issue path
    always_comb begin
        dv_d   = gnt_vld;
        chan_d = chan_q;
        data_d = data_q;
        rr_d   = rr_q;
        if (gnt_vld) begin
            chan_d = gnt_idx;
            rr_d   = gnt_idx;
        end
        for (int i = 0; i < N_CHAN; i++) begin
            if (gnt_oh[i]) begin
                data_d = samp_q[i];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < N_CHAN; i++) begin
                samp_q[i] <= '0;
                lock_q[i] <= '0;
            end
            pend_q <= '0;
            ovf_q  <= '0;
            rr_q   <= RR_RST;
            dv_q   <= 1'b0;
            chan_q <= '0;
            data_q <= '0;
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                samp_q[i] <= samp_d[i];
                lock_q[i] <= lock_d[i];
            end
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            rr_q   <= rr_d;
            dv_q   <= dv_d;
            chan_q <= chan_d;
            data_q <= data_d;
        end
    end

    assign dv_out   = dv_q;
    assign chan_out = chan_q;
    assign data_out = data_q;
    assign ovf_out  = ovf_q;

`ifdef PID_SCHED_DROP_CNT_EN
    logic [15:0] drop_q [N_CHAN];
    logic [15:0] drop_d [N_CHAN];

    // Counts registered ovf pulses, sticking at full scale.
    always_comb begin
        for (int i = 0; i < N_CHAN; i++) begin
            drop_d[i] = drop_q[i];
            if (ovf_q[i] && (drop_q[i] != 16'hFFFF)) begin
                drop_d[i] = drop_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < N_CHAN; i++) begin
                drop_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                drop_q[i] <= drop_d[i];
            end
        end
    end

    always_comb begin
        drop_cnt_out = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            drop_cnt_out[i*16 +: 16] = drop_q[i];
        end
    end
`else
    assign drop_cnt_out = '0;
`endif

endmodule

// File: tb/tb_pid_scheduler.sv
// tb_pid_scheduler: directed self-checking bench for pid_scheduler.
// Expected issues are queued at stimulus time and checked on dv_out.

module tb_pid_scheduler;

    localparam int N  = 8;
    localparam int WC = 5;
    localparam int WD = 18;
    localparam int LK = 6;

    logic            clk_in      = 1'b0;
    logic            rst_in      = 1'b1;
    logic [N-1:0]    src_dv_in   = '0;
    logic [N*WD-1:0] src_data_in = '0;
    logic [N-1:0]    chan_en_in  = '1;
    logic            dv_out;
    logic [WC-1:0]   chan_out;
    logic [WD-1:0]   data_out;
    logic [N-1:0]    ovf_out;
    logic [N*16-1:0] drop_cnt_out;

    pid_scheduler #(
        .N_CHAN  (N),
        .W_CHAN  (WC),
        .W_DIN   (WD),
        .LOCKOUT (LK)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .src_dv_in    (src_dv_in),
        .src_data_in  (src_data_in),
        .chan_en_in   (chan_en_in),
        .dv_out       (dv_out),
        .chan_out     (chan_out),
        .data_out     (data_out),
        .ovf_out      (ovf_out),
        .drop_cnt_out (drop_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [WC-1:0] ch;
        logic [WD-1:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample #1 after the edge, score any issue.
    task automatic step();
        exp_t e;
        @(posedge clk_in);
        #1;
        cyc++;
        if (dv_out === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_dv", 32'(dv_out), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_chan", 32'(chan_out), 32'(e.ch));
                chk("sb_data", 32'(data_out), 32'(e.d));
            end
        end
    endtask

    task automatic set_smp(input int ch, input logic [WD-1:0] d);
        src_dv_in[ch] = 1'b1;
        src_data_in[ch*WD +: WD] = d;
    endtask

    task automatic push(input int ch, input logic [WD-1:0] d);
        exp_t e;
        e.ch = WC'(ch);
        e.d  = d;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WD-1:0] v;
        int            last_dv;
        int            exp_drop;
        logic          exp_dv;
        logic          exp_ov;

        // Reset state
        step();
        step();
        chk("rst_dv", 32'(dv_out), 32'd0);
        chk("rst_chan", 32'(chan_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_ovf", 32'(ovf_out), 32'd0);
        chk("rst_drop", 32'(drop_cnt_out != '0), 32'd0);
        rst_in = 1'b0;
        step();

        // Single strobe on ch3: issue exactly two cycles later
        set_smp(3, 18'h1FFFF);
        push(3, 18'h1FFFF);
        step();
        src_dv_in = '0;
        chk("s1_dv_n1", 32'(dv_out), 32'd0);
        step();
        chk("s1_dv_n2", 32'(dv_out), 32'd1);
        step();
        chk("s1_dv_n3", 32'(dv_out), 32'd0);
        chk("s1_hold_chan", 32'(chan_out), 32'd3);
        chk("s1_hold_data", 32'(data_out), 32'h1FFFF);

        // All channels strobed together: round-robin from ch0
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        step();
        for (int i = 0; i < N; i++) begin
            v = WD'(i * 32'h4321) ^ 18'h20000;
            set_smp(i, v);
            push(i, v);
        end
        step();
        src_dv_in = '0;
        chk("s2_dv_n1", 32'(dv_out), 32'd0);
        for (int i = 0; i < N; i++) begin
            step();
            chk("s2_dv", 32'(dv_out), 32'd1);
            chk("s2_order", 32'(chan_out), 32'(i));
        end
        step();
        chk("s2_dv_end", 32'(dv_out), 32'd0);

        // ch2 strobed every cycle: issues 7 apart, overwrites flagged
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        step();
        last_dv = -1;
        for (int k = 0; k <= 20; k++) begin
            set_smp(2, WD'(32'h3FF00 + k));
            exp_dv = (k >= 1) && ((k - 1) % 7 == 0);
            exp_ov = (k >= 2) && ((k - 1) % 7 != 0);
            if (exp_dv) begin
                push(2, WD'(32'h3FF00 + k - 1));
            end
            step();
            chk("s3_dv", 32'(dv_out), 32'(exp_dv));
            chk("s3_ovf", 32'(ovf_out), exp_ov ? 32'h04 : 32'h00);
            if (dv_out === 1'b1) begin
                if (last_dv >= 0) begin
                    chk("s3_gap", 32'(cyc - last_dv), 32'(LK + 1));
                end
                last_dv = cyc;
            end
        end
        src_dv_in = '0;
        push(2, WD'(32'h3FF00 + 20));
        step();
        chk("s3_tail_dv0", 32'(dv_out), 32'd0);
        chk("s3_tail_ovf", 32'(ovf_out), 32'd0);
        step();
        chk("s3_tail_dv1", 32'(dv_out), 32'd1);
        chk("s3_tail_gap", 32'(cyc - last_dv), 32'(LK + 1));
`ifdef PID_SCHED_DROP_CNT_EN
        exp_drop = 17;
`else
        exp_drop = 0;
`endif
        chk("s3_drop2", 32'(drop_cnt_out[2*16 +: 16]), 32'(exp_drop));
        chk("s3_drop_others", 32'(drop_cnt_out[16 +: 16]), 32'd0);

        // ch5 disabled while pending: sample silently discarded
        step();
        set_smp(5, 18'h2ABCD);
        step();
        src_dv_in = '0;
        chk("s4_dv_a", 32'(dv_out), 32'd0);
        chan_en_in[5] = 1'b0;
        step();
        chk("s4_dv_b", 32'(dv_out), 32'd0);
        set_smp(5, 18'h11111);
        step();
        src_dv_in = '0;
        chk("s4_dv_c", 32'(dv_out), 32'd0);
        chk("s4_ovf_c", 32'(ovf_out), 32'd0);
        step();
        chk("s4_dv_d", 32'(dv_out), 32'd0);
        chk("s4_ovf_d", 32'(ovf_out), 32'd0);
        chan_en_in[5] = 1'b1;
        step();
        step();
        step();
        chk("s4_dv_reen", 32'(dv_out), 32'd0);
        set_smp(5, 18'h0BEEF);
        push(5, 18'h0BEEF);
        step();
        src_dv_in = '0;
        chk("s4_dv_e", 32'(dv_out), 32'd0);
        step();
        chk("s4_dv_f", 32'(dv_out), 32'd1);
        step();

        // ch1 pending, asynchronous reset mid-cycle
        set_smp(1, 18'h15555);
        step();
        src_dv_in = '0;
        #3;
        rst_in = 1'b1;
        #1;
        chk("s5_rst_dv", 32'(dv_out), 32'd0);
        chk("s5_rst_chan", 32'(chan_out), 32'd0);
        chk("s5_rst_data", 32'(data_out), 32'd0);
        chk("s5_rst_ovf", 32'(ovf_out), 32'd0);
        chk("s5_rst_drop", 32'(drop_cnt_out != '0), 32'd0);
        step();
        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s5_no_ch1", 32'(dv_out), 32'd0);
        end
        set_smp(6, 18'h3C3C3);
        push(6, 18'h3C3C3);
        step();
        src_dv_in = '0;
        chk("s5_dv_n1", 32'(dv_out), 32'd0);
        step();
        chk("s5_dv_n2", 32'(dv_out), 32'd1);
        step();
        chk("s5_dv_n3", 32'(dv_out), 32'd0);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pid_scheduler.md
PID_SCHEDULER -- requirements
Module: pid_scheduler

Interface
REQ-001 Parameter N_CHAN, default 8: number of requesting input channels.
REQ-002 Parameter W_CHAN, default 5: channel index width; SHALL satisfy 2^W_CHAN >= N_CHAN.
REQ-003 Parameter W_DIN, default 18: sample width, signed.
REQ-004 Parameter LOCKOUT, default 6: minimum idle cycles between two grants to the same channel (PID pipeline read-after-write guard).
REQ-005 Port: clk_in, input, 1: sole clock, all logic on rising edge.
REQ-006 Port: rst_in, input, 1: reset, asynchronous, active-high.
REQ-007 Port: src_dv_in, input, N_CHAN: per-channel sample strobe, one-cycle pulse.
REQ-008 Port: src_data_in, input, N_CHAN*W_DIN: per-channel signed samples; channel i occupies bits [i*W_DIN +: W_DIN].
REQ-009 Port: chan_en_in, input, N_CHAN: per-channel enable.
REQ-010 Port: dv_out, output, 1: issue strobe to PID filter.
REQ-011 Port: chan_out, output, W_CHAN: issued channel index.
REQ-012 Port: data_out, output, W_DIN: issued signed sample.
REQ-013 Port: ovf_out, output, N_CHAN: one-cycle pulse per channel when a pending sample is overwritten.
REQ-014 Port: drop_cnt_out, output, N_CHAN*16: per-channel drop counters (see Configuration).

Function
REQ-015 Each channel SHALL hold one sample register plus one pending bit; a strobe on an enabled channel captures the data and sets pending.
REQ-016 A strobe on a channel whose pending bit is set and which is not granted that cycle SHALL overwrite the held sample (newest wins) and pulse ovf_out[i] the next cycle.
REQ-017 A strobe on a channel granted in the same cycle SHALL issue the old sample, capture the new one and leave pending set; no ovf pulse.
REQ-018 A channel SHALL be eligible when pending=1, chan_en_in=1 and its lockout counter=0.
REQ-019 At most one grant per cycle, round-robin: search starts at last-granted index+1, wraps from N_CHAN-1 to 0.
REQ-020 On grant: pending cleared (unless REQ-017), lockout counter loaded with LOCKOUT, round-robin pointer set to the granted index.
REQ-021 Lockout counters SHALL decrement by 1 per cycle down to 0, independent of enable, strobes or pending state.
REQ-022 Outputs SHALL be registered: a grant decided in cycle n drives dv_out=1, chan_out, data_out in cycle n+1; minimum latency from src_dv_in to dv_out is 2 cycles.
REQ-023 Same-channel dv_out pulses SHALL be separated by at least LOCKOUT idle cycles on that channel.
REQ-024 With no grant, dv_out=0; chan_out and data_out hold their last values.
REQ-025 Deasserting chan_en_in[i] SHALL clear pending[i] the next cycle and ignore strobes on i while low; no ovf pulse for discarded samples.
REQ-026 src_data_in SHALL pass unmodified (no width change, no sign manipulation) to data_out.

Reset
REQ-027 While rst_in=1: pending bits, lockout counters, ovf_out, dv_out, chan_out, data_out all 0; round-robin pointer = N_CHAN-1 (channel 0 first after reset).
REQ-028 Reset asserted mid-operation SHALL discard all held samples; the first strobe after release follows the normal REQ-022 latency.
REQ-029 Drop counters (when compiled in) SHALL reset to 0.

Configuration
REQ-030 Macro PID_SCHED_DROP_CNT_EN defined: per-channel 16-bit counter increments on every ovf_out pulse, saturates at 0xFFFF, drives drop_cnt_out.
REQ-031 Macro PID_SCHED_DROP_CNT_EN undefined: no counter registers; drop_cnt_out constant 0; all other behaviour identical.

Verification
REQ-032 Reset, all channels enabled, single strobe ch3 data=0x1FFFF at cycle n -> dv_out=1, chan_out=3, data_out=0x1FFFF at cycle n+2 only.
REQ-033 Strobes on ch0..ch7 same cycle n -> dv_out in cycles n+2..n+9, chan_out 0,1,...,7, one each, data matching.
REQ-034 Ch2 strobed every cycle, LOCKOUT=6 -> ch2 dv_out pulses exactly 7 cycles apart; ovf_out[2] pulses on intermediate strobes; drop_cnt for ch2 counts them (macro on) or stays 0 (macro off).
REQ-035 Ch5 pending, chan_en_in[5] dropped before grant -> no dv_out for ch5, no ovf pulse; re-enable and strobe -> normal issue.
REQ-036 Ch1 pending, rst_in pulsed asynchronously mid-cycle -> all outputs 0 immediately, no ch1 issue after release; next strobe on ch6 issues in 2 cycles.
